// File: rtl/cache_op_arbiter.sv
`default_nettype none

// ============================================================================
// Package : cache_cfg_pkg
// Purpose : Shared cache geometry (key and value widths).
// Revision: 1.0 - initial release
// ============================================================================
package cache_cfg_pkg;
    localparam int KEY_WIDTH   = 16;
    localparam int VALUE_WIDTH = 32;
endpackage

// ============================================================================
// Module  : cache_op_arbiter
// Purpose : Round-robin arbiter sharing one cache controller between NUM_REQ
//           requesters. One operation in flight at a time; the result is
//           routed back to the requester that issued it.
// Ports   : clk/rst            - clock, synchronous active-high reset
//           req_*              - per-requester valid/ready and op/key/data
//           rsp_*              - response pulse with id, hit, data, error
//           cache_req_*/op/key/dat - operation towards the controller
//           cache_rsp_*        - completion pulse from the controller
// Option  : CACHE_ARB_TIMEOUT_EN - adds a watchdog that ends an operation
//           with rsp_err_o=1 after TIMEOUT_CYCLES cycles in ISSUE/WAIT.
// Revision: 1.0 - initial release
// ============================================================================
module cache_op_arbiter #(
    parameter int  NUM_REQ        = 4,
    parameter int  KEY_WIDTH      = cache_cfg_pkg::KEY_WIDTH,
    parameter int  VALUE_WIDTH    = cache_cfg_pkg::VALUE_WIDTH,
    parameter int  OP_WIDTH       = 2,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ*OP_WIDTH-1:0]      req_op_i,
    input  logic [NUM_REQ*KEY_WIDTH-1:0]     req_key_i,
    input  logic [NUM_REQ*VALUE_WIDTH-1:0]   req_dat_i,
    output logic                             rsp_valid_o,
    output logic [ID_W-1:0]                  rsp_id_o,
    output logic                             rsp_hit_o,
    output logic [VALUE_WIDTH-1:0]           rsp_dat_o,
    output logic                             rsp_err_o,
    output logic                             cache_req_valid_o,
    input  logic                             cache_req_ready_i,
    output logic [OP_WIDTH-1:0]              cache_op_o,
    output logic [KEY_WIDTH-1:0]             cache_key_o,
    output logic [VALUE_WIDTH-1:0]           cache_dat_o,
    input  logic                             cache_rsp_valid_i,
    input  logic                             cache_rsp_hit_i,
    input  logic [VALUE_WIDTH-1:0]           cache_rsp_dat_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [ID_W:0] c_NUM = (ID_W+1)'(NUM_REQ);

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [OP_WIDTH-1:0]     op_q, op_d;
    logic [KEY_WIDTH-1:0]    key_q, key_d;
    logic [VALUE_WIDTH-1:0]  dat_q, dat_d;
    logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
    logic                    rsp_hit_q, rsp_hit_d;
    logic [VALUE_WIDTH-1:0]  rsp_dat_q, rsp_dat_d;

    // Round-robin search: the request vector is doubled and shifted so bit j
    // of w_rot belongs to requester (ptr+1+j) mod NUM_REQ. The lowest set bit
    // is the winner; its offset is added back and wrapped once.
    logic [2*NUM_REQ-1:0]    w_dbl;
    logic [NUM_REQ-1:0]      w_rot;
    logic [ID_W:0]           w_shamt;
    logic [ID_W:0]           w_ofs;
    logic [ID_W:0]           w_sum;
    logic                    w_any;
    logic [ID_W-1:0]         w_grant;
    logic [NUM_REQ-1:0]      w_onehot;
    logic [OP_WIDTH-1:0]     w_sel_op;
    logic [KEY_WIDTH-1:0]    w_sel_key;
    logic [VALUE_WIDTH-1:0]  w_sel_dat;

    assign w_dbl    = {req_valid_i, req_valid_i};
    assign w_shamt  = {1'b0, ptr_q} + (ID_W+1)'(1);
    assign w_rot    = NUM_REQ'(w_dbl >> w_shamt);
    assign w_sum    = w_shamt + w_ofs;
    assign w_grant  = ID_W'((w_sum >= c_NUM) ? (w_sum - c_NUM) : w_sum);
    assign w_onehot = NUM_REQ'(1) << w_grant;

    always_comb begin
        w_any = 1'b0;
        w_ofs = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_any = 1'b1;
                w_ofs = (ID_W+1)'(i);
            end
        end
    end

    always_comb begin
        w_sel_op  = '0;
        w_sel_key = '0;
        w_sel_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_sel_op  = req_op_i[i*OP_WIDTH +: OP_WIDTH];
                w_sel_key = req_key_i[i*KEY_WIDTH +: KEY_WIDTH];
                w_sel_dat = req_dat_i[i*VALUE_WIDTH +: VALUE_WIDTH];
            end
        end
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               rsp_err_q, rsp_err_d;
    logic               w_expire;

    // Expiry is decided one count early so RESP is entered exactly when the
    // counter would reach TIMEOUT_CYCLES.
    assign w_expire  = (cnt_q == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err_o = rsp_err_q;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end
`else
    assign rsp_err_o = 1'b0;
`endif

    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        id_d              = id_q;
        op_d              = op_q;
        key_d             = key_q;
        dat_d             = dat_q;
        rsp_id_d          = rsp_id_q;
        rsp_hit_d         = rsp_hit_q;
        rsp_dat_d         = rsp_dat_q;
`ifdef CACHE_ARB_TIMEOUT_EN
        rsp_err_d         = rsp_err_q;
`endif
        req_ready_o       = '0;
        cache_req_valid_o = 1'b0;
        rsp_valid_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    req_ready_o = w_onehot;
                    op_d        = w_sel_op;
                    key_d       = w_sel_key;
                    dat_d       = w_sel_dat;
                    ptr_d       = w_grant;
                    id_d        = w_grant;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cache_req_valid_o = 1'b1;
`ifdef CACHE_ARB_TIMEOUT_EN
                // Expiry wins over a same-cycle accept: the operation is dropped.
                if (w_expire) begin
                    rsp_id_d  = id_q;
                    rsp_hit_d = 1'b0;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end else
`endif
                if (cache_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cache_rsp_valid_i) begin
                    rsp_id_d  = id_q;
                    rsp_hit_d = cache_rsp_hit_i;
                    rsp_dat_d = cache_rsp_dat_i;
`ifdef CACHE_ARB_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                    state_d   = S_RESP;
                end
`ifdef CACHE_ARB_TIMEOUT_EN
                else if (w_expire) begin
                    rsp_id_d  = id_q;
                    rsp_hit_d = 1'b0;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end
`endif
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= ID_W'(NUM_REQ - 1);
            id_q      <= '0;
            op_q      <= '0;
            key_q     <= '0;
            dat_q     <= '0;
            rsp_id_q  <= '0;
            rsp_hit_q <= 1'b0;
            rsp_dat_q <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
            rsp_err_q <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            op_q      <= op_d;
            key_q     <= key_d;
            dat_q     <= dat_d;
            rsp_id_q  <= rsp_id_d;
            rsp_hit_q <= rsp_hit_d;
            rsp_dat_q <= rsp_dat_d;
`ifdef CACHE_ARB_TIMEOUT_EN
            rsp_err_q <= rsp_err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign cache_op_o  = op_q;
    assign cache_key_o = key_q;
    assign cache_dat_o = dat_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_dat_o   = rsp_dat_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_op_arbiter.sv
`default_nettype none

// ============================================================================
// Module  : tb_cache_op_arbiter
// Purpose : Self-checking bench for cache_op_arbiter. A transaction-level
//           model (grant pointer, outstanding operation, expected response)
//           predicts every output each cycle; directed scenarios pin the model
//           with literal expectations. Build with CACHE_ARB_TIMEOUT_EN to
//           also exercise the watchdog (TIMEOUT_CYCLES = 8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_op_arbiter;

    localparam int N  = 4;
    localparam int KW = cache_cfg_pkg::KEY_WIDTH;
    localparam int VW = cache_cfg_pkg::VALUE_WIDTH;
    localparam int OW = 2;
    localparam int TO = 8;
    localparam int IW = $clog2(N);
`ifdef CACHE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*OW-1:0]   req_op  = '0;
    logic [N*KW-1:0]   req_key = '0;
    logic [N*VW-1:0]   req_dat = '0;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic              rsp_hit;
    logic [VW-1:0]     rsp_dat;
    logic              rsp_err;
    logic              c_valid;
    logic              c_ready = 1'b0;
    logic [OW-1:0]     c_op;
    logic [KW-1:0]     c_key;
    logic [VW-1:0]     c_dat;
    logic              c_rsp_valid = 1'b0;
    logic              c_rsp_hit = 1'b0;
    logic [VW-1:0]     c_rsp_dat = '0;

    cache_op_arbiter #(
        .NUM_REQ(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW),
        .OP_WIDTH(OW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_key_i(req_key), .req_dat_i(req_dat),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_hit_o(rsp_hit),
        .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .cache_req_valid_o(c_valid), .cache_req_ready_i(c_ready),
        .cache_op_o(c_op), .cache_key_o(c_key), .cache_dat_o(c_dat),
        .cache_rsp_valid_i(c_rsp_valid), .cache_rsp_hit_i(c_rsp_hit),
        .cache_rsp_dat_i(c_rsp_dat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus knobs
    logic [N-1:0]  mask = '0;
    int            p_valid = 0, p_ready = 100, p_spur = 0;
    int            lat_min = 1, lat_max = 1;
    bit            force_spur = 0;
    bit            fix_req = 0;
    logic [OW-1:0] fix_op = '0;
    logic [KW-1:0] fix_key = '0;
    logic [VW-1:0] fix_wdat = '0;
    bit            fix_rsp = 0;
    logic          fix_hit = 1'b0;
    logic [VW-1:0] fix_rdat = '0;
    logic [N-1:0]  drop = '0;

    // Transaction-level model
    int            m_ptr;
    bit            m_free, m_issue, m_wait, m_due;
    int            m_age, m_cnt;
    int            t_id;
    logic [OW-1:0] t_op;
    logic [KW-1:0] t_key;
    logic [VW-1:0] t_dat;
    int            e_id;
    logic          e_hit, e_err;
    logic [VW-1:0] e_dat;

    // Logs of observed DUT events
    int            g_log[$];
    logic [N-1:0]  rdy_log[$];
    int            acc_cyc[$];
    int            r_id[$];
    int            r_cyc[$];
    logic          r_hit[$];
    logic          r_err[$];
    logic [VW-1:0] r_dat[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        g_log.delete(); rdy_log.delete(); acc_cyc.delete();
        r_id.delete(); r_cyc.delete(); r_hit.delete(); r_err.delete(); r_dat.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0; drop = '0;
        c_ready = 1'b0; c_rsp_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("reset req_ready", 64'(req_ready), 64'(0));
        chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset rsp_err", 64'(rsp_err), 64'(0));
        chk("reset rsp_dat", 64'(rsp_dat), 64'(0));
        chk("reset cache_req_valid", 64'(c_valid), 64'(0));
        chk("reset cache_op", 64'(c_op), 64'(0));
        chk("reset cache_key", 64'(c_key), 64'(0));
        chk("reset cache_dat", 64'(c_dat), 64'(0));
        rst = 1'b0;
        m_ptr = N - 1; m_free = 1; m_issue = 0; m_wait = 0; m_due = 0;
        m_age = 0; m_cnt = 0;
        clear_logs();
    endtask

    // One clock cycle: drive inputs, predict outputs, compare, advance model.
    task automatic step();
        bit           pulse, n_issue, n_wait, n_due, n_free;
        int           g;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        cyc++;
        req_valid = req_valid & ~drop;
        drop = '0;
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && mask[i] && $urandom_range(99) < p_valid) begin
                req_valid[i] = 1'b1;
                req_op[i*OW +: OW]  = fix_req ? fix_op   : OW'($urandom);
                req_key[i*KW +: KW] = fix_req ? fix_key  : KW'($urandom);
                req_dat[i*VW +: VW] = fix_req ? fix_wdat : VW'($urandom);
            end
        end
        c_ready = ($urandom_range(99) < p_ready);
        pulse = 0;
        if (m_wait) begin
            m_cnt--;
            if (m_cnt == 0) pulse = 1;
        end else if (force_spur) begin
            pulse = 1;
        end else if (!(m_issue && c_ready) && $urandom_range(99) < p_spur) begin
            pulse = 1;
        end
        force_spur  = 0;
        c_rsp_valid = pulse;
        c_rsp_hit   = fix_rsp ? fix_hit  : 1'($urandom);
        c_rsp_dat   = fix_rsp ? fix_rdat : VW'($urandom);
        #1;

        g = -1;
        exp_ready = '0;
        if (m_free && (|req_valid)) begin
            for (int k = 1; k <= N; k++) begin
                automatic int c = (m_ptr + k) % N;
                if (g < 0 && req_valid[c]) g = c;
            end
            exp_ready[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("cache_req_valid", 64'(c_valid), 64'(m_issue));
        if (m_issue) begin
            chk("cache_op", 64'(c_op), 64'(t_op));
            chk("cache_key", 64'(c_key), 64'(t_key));
            chk("cache_dat", 64'(c_dat), 64'(t_dat));
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(m_due));
        if (m_due) begin
            chk("rsp_id", 64'(rsp_id), 64'(e_id));
            chk("rsp_hit", 64'(rsp_hit), 64'(e_hit));
            chk("rsp_dat", 64'(rsp_dat), 64'(e_dat));
            chk("rsp_err", 64'(rsp_err), 64'(e_err));
        end
        if (rsp_valid) begin
            r_id.push_back(int'(rsp_id)); r_cyc.push_back(cyc);
            r_hit.push_back(rsp_hit); r_err.push_back(rsp_err); r_dat.push_back(rsp_dat);
        end

        n_issue = m_issue; n_wait = m_wait; n_due = 0; n_free = m_free;
        if (m_due) n_free = 1;
        if (m_issue || m_wait) m_age++;
        if (m_issue) begin
            if (TO_EN && m_age == TO) begin
                n_issue = 0; n_due = 1;
                e_id = t_id; e_hit = 0; e_dat = '0; e_err = 1;
            end else if (c_ready) begin
                n_issue = 0; n_wait = 1;
                m_cnt = $urandom_range(lat_max, lat_min);
            end
        end
        if (m_wait) begin
            if (pulse) begin
                n_wait = 0; n_due = 1;
                e_id = t_id; e_hit = c_rsp_hit; e_dat = c_rsp_dat; e_err = 0;
            end else if (TO_EN && m_age == TO) begin
                n_wait = 0; n_due = 1;
                e_id = t_id; e_hit = 0; e_dat = '0; e_err = 1;
            end
        end
        if (g >= 0) begin
            t_id = g; t_op = req_op[g*OW +: OW];
            t_key = req_key[g*KW +: KW]; t_dat = req_dat[g*VW +: VW];
            m_ptr = g; n_free = 0; n_issue = 1; m_age = 0;
            drop[g] = 1'b1;
            g_log.push_back(g); rdy_log.push_back(req_ready); acc_cyc.push_back(cyc);
        end
        m_issue = n_issue; m_wait = n_wait; m_due = n_due; m_free = n_free;
    endtask

    task automatic run_grants(input int n, input int budget);
        for (int k = 0; k < budget && g_log.size() < n; k++) step();
        chk("grant count within budget", 64'(g_log.size() >= n), 64'(1));
    endtask

    task automatic run_rsps(input int n, input int budget);
        for (int k = 0; k < budget && r_id.size() < n; k++) step();
        chk("response count within budget", 64'(r_id.size() >= n), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Single request from requester 2, two-cycle controller latency
        do_reset();
        mask = 4'b0100; p_valid = 100; p_ready = 100; p_spur = 0;
        lat_min = 2; lat_max = 2;
        fix_req = 1; fix_op = 2'd1; fix_key = KW'(16'h00A5); fix_wdat = VW'(32'h0000BEEF);
        fix_rsp = 1; fix_hit = 1'b1; fix_rdat = VW'(32'h1234);
        run_grants(1, 10);
        mask = '0;
        run_rsps(1, 20);
        if (r_id.size() >= 1 && rdy_log.size() >= 1) begin
            chk("t1 ready onehot", 64'(rdy_log[0]), 64'(4'b0100));
            chk("t1 rsp id", 64'(r_id[0]), 64'(2));
            chk("t1 rsp hit", 64'(r_hit[0]), 64'(1));
            chk("t1 rsp dat", 64'(r_dat[0]), 64'(32'h1234));
            chk("t1 turnaround", 64'(r_cyc[0] - acc_cyc[0]), 64'(4));
        end
        fix_rsp = 0;

        // All requesters continuously valid: strict rotation 0,1,2,3,0
        do_reset();
        fix_req = 0; mask = 4'b1111; p_valid = 100; p_ready = 100;
        lat_min = 1; lat_max = 3;
        run_grants(5, 80);
        run_rsps(5, 40);
        if (g_log.size() >= 5 && r_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("t2 grant order", 64'(g_log[k]), 64'(k % N));
                chk("t2 rsp id order", 64'(r_id[k]), 64'(k % N));
            end
        end

        // Requester 1, controller stalls 5 cycles
        do_reset();
        mask = 4'b0010; p_valid = 100; p_ready = 0;
        fix_req = 1; fix_op = 2'd3; fix_key = KW'(16'h0BEE); fix_wdat = VW'(32'h5A5A5A5A);
        run_grants(1, 10);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3 stall valid", 64'(c_valid), 64'(1));
            chk("t3 stall key", 64'(c_key), 64'(16'h0BEE));
            chk("t3 stall op", 64'(c_op), 64'(3));
            chk("t3 stall no ready", 64'(req_ready), 64'(0));
        end
        mask = '0; p_ready = 100;
        run_rsps(1, 20);

        // Reset during WAIT, then a stray completion pulse
        do_reset();
        fix_req = 0; mask = 4'b0010; p_valid = 100; p_ready = 100;
        lat_min = 50; lat_max = 50;
        for (int k = 0; k < 20 && !m_wait; k++) step();
        chk("t4 reached wait", 64'(m_wait), 64'(1));
        step();
        do_reset();
        mask = '0; force_spur = 1;
        for (int k = 0; k < 4; k++) step();
        chk("t4 no response after reset", 64'(r_id.size()), 64'(0));
        mask = 4'b1111; lat_min = 1; lat_max = 2;
        run_grants(1, 10);
        if (g_log.size() >= 1) chk("t4 first grant", 64'(g_log[0]), 64'(0));
        mask = '0;
        run_rsps(1, 20);

`ifdef CACHE_ARB_TIMEOUT_EN
        // Controller never completes: watchdog response, then a late pulse
        do_reset();
        mask = 4'b0001; p_valid = 100; p_ready = 100;
        lat_min = 200; lat_max = 200;
        run_grants(1, 10);
        mask = '0;
        run_rsps(1, 30);
        if (r_id.size() >= 1) begin
            chk("t5 err", 64'(r_err[0]), 64'(1));
            chk("t5 dat", 64'(r_dat[0]), 64'(0));
            chk("t5 hit", 64'(r_hit[0]), 64'(0));
            chk("t5 latency", 64'(r_cyc[0] - acc_cyc[0]), 64'(9));
        end
        force_spur = 1;
        for (int k = 0; k < 4; k++) step();
        chk("t5 late pulse ignored", 64'(r_id.size()), 64'(1));
`endif

        // Randomized traffic
        do_reset();
        fix_req = 0; fix_rsp = 0;
        mask = 4'b1111; p_valid = 30; p_ready = 60; p_spur = 5;
        lat_min = 1; lat_max = 5;
        for (int k = 0; k < 3000; k++) step();
        chk("random traffic produced grants", 64'(g_log.size() > 100), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cache_op_arbiter.md
# cache_op_arbiter

Round-robin arbiter that shares the single cache controller/memory datapath between `NUM_REQ` independent requesters (for example, several OBI front ends or an internal maintenance agent). It accepts one operation at a time, forwards it to the controller, waits for completion and routes the result back to the originating requester. It sits between the requester-side interfaces and the `controller`/`memory_block` pair.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `KEY_WIDTH`, `cache_cfg_pkg::KEY_WIDTH`: key width.
- `VALUE_WIDTH`, `cache_cfg_pkg::VALUE_WIDTH`: value width.
- `OP_WIDTH`, 2: operation code width; the code is passed through opaquely.
- `TIMEOUT_CYCLES`, 64: watchdog limit. Used only with `CACHE_ARB_TIMEOUT_EN`.
- `ID_W`, `$clog2(NUM_REQ)`: requester id width (derived, do not override).

Ports (one clock domain; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester accept, one-hot or zero.
- `req_op_i`  in  NUM_REQ×OP_WIDTH  operation per requester.
- `req_key_i`  in  NUM_REQ×KEY_WIDTH  key per requester.
- `req_dat_i`  in  NUM_REQ×VALUE_WIDTH  write data per requester.
- `rsp_valid_o`  out  1  response pulse.
- `rsp_id_o`  out  ID_W  index of the requester the response belongs to.
- `rsp_hit_o`  out  1  hit flag.
- `rsp_dat_o`  out  VALUE_WIDTH  read data.
- `rsp_err_o`  out  1  timeout error flag. Tied to 0 without the macro.
- `cache_req_valid_o`  out  1  operation valid to controller.
- `cache_req_ready_i`  in  1  controller accepts operation.
- `cache_op_o`  out  OP_WIDTH  operation.
- `cache_key_o`  out  KEY_WIDTH  key.
- `cache_dat_o`  out  VALUE_WIDTH  write data.
- `cache_rsp_valid_i`  in  1  controller completion pulse.
- `cache_rsp_hit_i`  in  1  hit, qualified by `cache_rsp_valid_i`.
- `cache_rsp_dat_i`  in  VALUE_WIDTH  read data, qualified by `cache_rsp_valid_i`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid_i` is high, the grant `g` is the first set bit searching from `ptr+1` upward, wrapping modulo `NUM_REQ`.
  - `req_ready_o[g]`=1 combinationally in that cycle; that is the handshake cycle.
  - In the same cycle, capture `op`/`key`/`dat` of `g`, set `ptr<=g`, `id<=g`, and go to ISSUE.
- **ISSUE**
  - `cache_req_valid_o`=1 with the captured fields held stable.
  - On `cache_req_ready_i`=1, go to WAIT.
- **WAIT**
  - On `cache_rsp_valid_i`=1, capture hit and data and go to RESP.
- **RESP**
  - `rsp_valid_o`=1 for exactly one cycle with `rsp_id_o`=id, then go to IDLE.
  - Responses have no backpressure.
- `cache_rsp_valid_i` is ignored outside WAIT. The controller never completes in the same cycle it accepts.
- `req_ready_o` is 0 in every state except IDLE. A requester holds `req_valid_i` and its fields stable until it sees ready.
- Only one operation is outstanding at a time. No requester can be granted twice while another valid requester is waiting.
- On reset, including mid-operation:
  - State returns to IDLE and any in-flight operation is dropped.
  - `ptr`=NUM_REQ-1, so requester 0 wins first.
  - All outputs are 0: `req_ready_o`, `rsp_*`, and `cache_req_valid_o`. `cache_op_o`/`cache_key_o`/`cache_dat_o` are 0.

## Timing
- Accept at cycle T → `cache_req_valid_o` at T+1.
- With `cache_req_ready_i` at T+1, WAIT starts at T+2.
- `cache_rsp_valid_i` at cycle C in WAIT → `rsp_valid_o` at C+1.
- Minimum turnaround is T → T+3 response. The next accept is possible at T+4.
- `rsp_hit_o`, `rsp_dat_o`, `rsp_id_o` and `rsp_err_o` are registered and valid only while `rsp_valid_o`=1. They are held, not cleared, otherwise.

## Configuration
- `CACHE_ARB_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on the IDLE→ISSUE transition.
  - It increments every cycle in ISSUE or WAIT.
  - When it reaches `TIMEOUT_CYCLES`, go to RESP with `rsp_err_o`=1, `rsp_hit_o`=0, `rsp_dat_o`=0, and drop `cache_req_valid_o`.
  - A late `cache_rsp_valid_i` arriving in IDLE is discarded.
- Not defined: no counter exists, `rsp_err_o` is constant 0, and the FSM waits indefinitely.

## Test plan
- Reset, then requester 2 only: `op`=1, `key`=0xA5, controller ready immediately, response 2 cycles later with hit=1, dat=0x1234. Expect `req_ready_o`=4'b0100 in the accept cycle, `rsp_valid_o` one cycle after the completion pulse, `rsp_id_o`=2, hit=1, dat=0x1234.
- All four requesters held valid continuously. Expect grants in order 0,1,2,3,0 with exactly one `rsp_valid_o` per grant, ids matching the grant order.
- Requester 1 only, `cache_req_ready_i` low for 5 cycles. Expect `cache_req_valid_o`, `cache_key_o` and `cache_op_o` stable for all 5 cycles, and no `req_ready_o` on any requester.
- `rst` asserted during WAIT, then `cache_rsp_valid_i` pulses. Expect no `rsp_valid_o`, all outputs 0, and the next grant goes to requester 0.
- With `CACHE_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, the controller never responds. Expect `rsp_valid_o`=1 with `rsp_err_o`=1 and `rsp_dat_o`=0 on the 9th cycle after accept, then a late `cache_rsp_valid_i` is ignored.
